pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: flops in the `locked` synchronizer; legal range >=2.
REQ-002 SHALL provide parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required; legal range >=1.
REQ-003 SHALL provide parameter HOLD_CYCLES, default 16: extra reset-hold cycles after stability; legal range >=1.
REQ-004 SHALL provide parameter CNT_W, default 8: width of the lock-loss counter.
REQ-005 SHALL provide port clk, input, 1 bit: single clock, the PLL output clock; all logic is rising-edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL provide port locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-008 SHALL provide port sw_reset_req, input, 1 bit: synchronous request to re-run the hold phase.
REQ-009 SHALL provide port sys_reset, output, 1 bit: active-high reset for downstream logic, deasserted synchronously.
REQ-010 SHALL provide port ready, output, 1 bit: high only in RUN.
REQ-011 SHALL provide port state, output, 2 bits: current FSM state encoding.
REQ-012 SHALL provide port lock_loss, output, 1 bit: one-cycle pulse on loss of lock while in RUN.
REQ-013 SHALL provide port lock_loss_count, output, CNT_W bits: saturating count of lock_loss pulses.

Function
REQ-014 SHALL pass `locked` through a SYNC_STAGES flop chain; the last stage is locked_s, and only locked_s is used by the FSM.
REQ-015 SHALL implement FSM states WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3, with one internal cycle counter sized to hold max(STABLE_CYCLES, HOLD_CYCLES)-1.
REQ-016 In WAIT_LOCK, the FSM SHALL hold the counter at 0 and go to STABILIZE on the edge where locked_s=1.
REQ-017 In STABILIZE, when locked_s=0 the FSM SHALL go to WAIT_LOCK and clear the counter.
REQ-018 In STABILIZE, when locked_s=1 and counter==STABLE_CYCLES-1 the FSM SHALL go to HOLD and clear the counter; otherwise it SHALL increment the counter.
REQ-019 In HOLD, when locked_s=0 the FSM SHALL go to WAIT_LOCK and clear the counter.
REQ-020 In HOLD, when counter==HOLD_CYCLES-1 the FSM SHALL go to RUN; otherwise it SHALL increment the counter.
REQ-021 In RUN, when locked_s=0 the FSM SHALL go to WAIT_LOCK, pulse lock_loss for exactly one cycle, and increment lock_loss_count; the count SHALL saturate at all-ones.
REQ-022 In RUN, when locked_s=1 and sw_reset_req=1 the FSM SHALL go to HOLD with the counter cleared; this does not pulse lock_loss.
REQ-023 When loss of lock and sw_reset_req occur in the same cycle, loss of lock SHALL win.
REQ-024 In states other than RUN, sw_reset_req SHALL be ignored.
REQ-025 sys_reset, ready, state and lock_loss SHALL be driven directly from flops (glitch-free), and sys_reset=~ready at all times.
REQ-026 sys_reset SHALL deassert and ready SHALL assert on the same edge the state register becomes RUN.
REQ-027 sys_reset SHALL reassert on the same edge RUN is left.
REQ-028 Latency: if locked rises before edge k and stays high, the FSM SHALL enter RUN at edge k+SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES.
REQ-029 A locked glitch shorter than one clock SHALL be tolerated without metastability propagation; if sampled, it SHALL restart qualification per REQ-017 and REQ-019.

Reset
REQ-030 While rst=1, the block SHALL immediately drive: synchronizer flops=0, state=WAIT_LOCK, counter=0, sys_reset=1, ready=0, lock_loss=0, lock_loss_count=0.
REQ-031 Release of rst SHALL cause no other output change until locked_s is sampled; assertion of rst mid-sequence (any state) SHALL abort to the REQ-030 values asynchronously.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CNT_W=2)
REQ-032 The bench SHALL check: locked rises before edge 10 and holds -> state 1 at edge 12, state 2 at edge 20, state 3 with sys_reset=0 and ready=1 at edge 24.
REQ-033 The bench SHALL check: locked drops for 3 cycles while in STABILIZE at counter=5 -> return to WAIT_LOCK, and full qualification restarts from 0 on relock.
REQ-034 The bench SHALL check: in RUN, drop locked 4 times with relock -> 4 lock_loss pulses of width 1, and lock_loss_count reads 1, 2, 3, 3 (saturated).
REQ-035 The bench SHALL check: in RUN, sw_reset_req=1 for 1 cycle -> sys_reset=1 for exactly 4 cycles, then RUN, with lock_loss_count unchanged.
REQ-036 The bench SHALL check: sw_reset_req=1 on the same cycle locked_s falls in RUN -> state WAIT_LOCK and one lock_loss pulse.
REQ-037 The bench SHALL check: rst asserted mid-HOLD -> all outputs at REQ-030 values before the next clk edge, and lock_loss_count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronizes lock, qualifies it for STABLE_CYCLES, holds
// downstream reset for HOLD_CYCLES more, then releases; counts lock losses in RUN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             sw_reset_req,
  output logic             sys_reset,
  output logic             ready,
  output logic [1:0]       state,
  output logic             lock_loss,
  output logic [CNT_W-1:0] lock_loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(STABLE_CYCLES - 1);
  localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state_q, state_d;
  logic [CTR_W-1:0]       cnt_q, cnt_d;
  logic                   ready_d;
  logic                   lock_loss_d;
  logic [CNT_W-1:0]       count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Loss of lock is tested first in every state, so it beats a same-cycle software request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_loss_d = 1'b0;
    count_d     = lock_loss_count;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = WAIT_LOCK;
          cnt_d       = '0;
          lock_loss_d = 1'b1;
          if (lock_loss_count != {CNT_W{1'b1}}) count_d = lock_loss_count + 1'b1;
        end else if (sw_reset_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  // ready/sys_reset are registered from the next state so they switch on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      ready           <= 1'b0;
      sys_reset       <= 1'b1;
      lock_loss       <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ready           <= ready_d;
      sys_reset       <= ~ready_d;
      lock_loss       <= lock_loss_d;
      lock_loss_count <= count_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected outputs are queued per clock edge
// when stimulus is applied and compared at the following falling edges.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic       lock_loss;
  logic [1:0] lock_loss_count;

  pll_reset_sequencer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .CNT_W        (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .locked         (locked),
    .sw_reset_req   (sw_reset_req),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .state          (state),
    .lock_loss      (lock_loss),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) if (!rst) edge_n <= edge_n + 1;

  typedef struct {
    int    at_edge;
    string tag;
    int    st;
    int    ll;
    int    cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_exp(input int at_edge, input string tag, input int st, input int ll, input int cnt);
    exp_t e;
    e.at_edge = at_edge;
    e.tag     = tag;
    e.st      = st;
    e.ll      = ll;
    e.cnt     = cnt;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] obs, input int expv);
    tests++;
    assert (obs === 32'(expv))
    else begin
      fails++;
      $error("FAIL %s.%s @edge %0d: observed %0d expected %0d", tag, field, edge_n, obs, expv);
    end
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
      e = sb.pop_front();
      cmp(e.tag, "edge", 32'(edge_n), e.at_edge);
      cmp(e.tag, "state", 32'(state), e.st);
      cmp(e.tag, "sys_reset", 32'(sys_reset), (e.st != 3) ? 1 : 0);
      cmp(e.tag, "ready", 32'(ready), (e.st == 3) ? 1 : 0);
      cmp(e.tag, "lock_loss", 32'(lock_loss), e.ll);
      cmp(e.tag, "lock_loss_count", 32'(lock_loss_count), e.cnt);
    end
  endtask

  task automatic run_to(input int n);
    check_now();
    while (edge_n < n) begin
      @(negedge clk);
      check_now();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    int exp_cnt;

    // Asynchronous reset values
    #1 rst = 1'b1;
    #1;
    push_exp(0, "reset", 0, 0, 0);
    check_now();
    @(negedge clk);
    rst = 1'b0;

    // Power-up qualification: locked rises before edge 10
    push_exp(5, "idle_after_rst", 0, 0, 0);
    run_to(9);
    locked = 1'b1;
    push_exp(11, "sync_delay", 0, 0, 0);
    push_exp(12, "enter_stabilize", 1, 0, 0);
    push_exp(19, "still_stabilize", 1, 0, 0);
    push_exp(20, "enter_hold", 2, 0, 0);
    push_exp(23, "still_hold", 2, 0, 0);
    push_exp(24, "enter_run", 3, 0, 0);
    push_exp(26, "run_steady", 3, 0, 0);
    run_to(26);

    // Software reset request: 4 cycles of hold, count untouched
    sw_reset_req = 1'b1;
    push_exp(27, "sw_hold_1", 2, 0, 0);
    push_exp(28, "sw_hold_2", 2, 0, 0);
    push_exp(30, "sw_hold_4", 2, 0, 0);
    push_exp(31, "sw_back_run", 3, 0, 0);
    run_to(27);
    sw_reset_req = 1'b0;
    run_to(33);

    // Four lock losses in RUN, counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      n = edge_n;
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      locked = 1'b0;
      push_exp(n + 2, "loss_pre", 3, 0, (i > 3) ? 3 : i);
      push_exp(n + 3, "loss_pulse", 0, 1, exp_cnt);
      push_exp(n + 4, "loss_pulse_end", 1, 0, exp_cnt);
      push_exp(n + 16, "loss_relock_run", 3, 0, exp_cnt);
      run_to(n + 1);
      locked = 1'b1;
      run_to(n + 18);
    end

    // Lock loss and software request in the same cycle: loss wins
    n = edge_n;
    locked = 1'b0;
    push_exp(n + 2, "tie_pre", 3, 0, 3);
    push_exp(n + 3, "tie_loss_wins", 0, 1, 3);
    push_exp(n + 4, "tie_pulse_end", 0, 0, 3);
    run_to(n + 2);
    sw_reset_req = 1'b1;
    run_to(n + 3);
    sw_reset_req = 1'b0;
    run_to(n + 6);

    // 3-cycle dropout during STABILIZE at counter 5 restarts qualification
    m = edge_n;
    locked = 1'b1;
    push_exp(m + 3, "stab_entry", 1, 0, 3);
    push_exp(m + 8, "stab_cnt5", 1, 0, 3);
    push_exp(m + 9, "stab_abort", 0, 0, 3);
    push_exp(m + 11, "stab_waiting", 0, 0, 3);
    push_exp(m + 12, "stab_reentry", 1, 0, 3);
    push_exp(m + 19, "stab_full_again", 1, 0, 3);
    push_exp(m + 20, "stab_hold", 2, 0, 3);
    push_exp(m + 23, "stab_hold_end", 2, 0, 3);
    push_exp(m + 24, "stab_run", 3, 0, 3);
    run_to(m + 6);
    locked = 1'b0;
    run_to(m + 9);
    locked = 1'b1;
    run_to(m + 25);

    // Reset asserted mid-HOLD takes effect without a clock edge
    sw_reset_req = 1'b1;
    push_exp(m + 26, "pre_rst_hold", 2, 0, 3);
    run_to(m + 26);
    sw_reset_req = 1'b0;
    rst = 1'b1;
    #1;
    push_exp(edge_n, "rst_mid_hold", 0, 0, 0);
    check_now();

    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
